// File: rtl/private_key_gen.sv
// private_key_gen: computes d = e^-1 mod y with the iterative extended
// Euclidean algorithm. Each quotient comes from a WIDTH-cycle restoring
// shift-subtract divider that also forms q*t1 bit-serially, so no
// multiplier is needed. key_valid reports whether the inverse exists.
module private_key_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] public_key,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] private_key,
  output logic             key_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_DIV    = 3'd2,
    S_UPDATE = 3'd3,
    S_FIX    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_ZERO  = {WIDTH{1'b0}};
  localparam logic signed [WIDTH+1:0] T_ZERO = {(WIDTH+2){1'b0}};
  localparam logic signed [WIDTH+1:0] T_ONE  = {{(WIDTH+1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  // Latched operands
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] y_q, y_d;
  // Euclid remainders and Bezout coefficients
  logic [WIDTH-1:0] r0_q, r0_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic signed [WIDTH+1:0] t0_q, t0_d;
  logic signed [WIDTH+1:0] t1_q, t1_d;
  // Divider: dividend shift register, partial remainder, q*t1 accumulator
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic signed [WIDTH+1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Registered outputs
  logic [WIDTH-1:0] key_q, key_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Divider step signals
  logic [WIDTH:0]          trial_s;
  logic [WIDTH+1:0]        diff_s;
  logic                    qb_s;
  logic [WIDTH-1:0]        rem_next_s;
  logic signed [WIDTH+1:0] p_next_s;
  logic signed [WIDTH+1:0] t0_adj_s;
  logic                    degen_s;

  // One restoring-division step, the matching product accumulation, and the
  // final sign correction of the inverse.
  always_comb begin
    trial_s    = {rem_q, quo_q[WIDTH-1]};
    diff_s     = {1'b0, trial_s} - {2'b00, r1_q};
    qb_s       = ~diff_s[WIDTH+1];
    // The remainder is always below r1 so it fits in WIDTH bits.
    rem_next_s = qb_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
    p_next_s   = (p_q <<< 1) + (qb_s ? t1_q : T_ZERO);
    t0_adj_s   = t0_q + $signed({2'b00, y_q});
    degen_s    = (e_q == W_ZERO) || (y_q[WIDTH-1:1] == W_ZERO[WIDTH-1:1]) || (e_q >= y_q);
  end

  // Next-state and datapath update for the controller.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    y_d     = y_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          e_d     = public_key;
          y_d     = y;
          busy_d  = 1'b1;
          key_d   = W_ZERO;
          valid_d = 1'b0;
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        if (degen_s) begin
          state_d = S_DONE;
        end else begin
          r0_d    = y_q;
          r1_d    = e_q;
          t0_d    = T_ZERO;
          t1_d    = T_ONE;
          quo_d   = y_q;
          rem_d   = W_ZERO;
          p_d     = T_ZERO;
          cnt_d   = CNT_ZERO;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
        rem_d = rem_next_s;
        p_d   = p_next_s;
        if (cnt_q == CNT_LAST) begin
          state_d = S_UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_UPDATE: begin
        r0_d  = r1_q;
        r1_d  = rem_q;
        t0_d  = t1_q;
        t1_d  = t0_q - p_q;
        // Next division divides the old r1 by the remainder just found.
        quo_d = r1_q;
        rem_d = W_ZERO;
        p_d   = T_ZERO;
        cnt_d = CNT_ZERO;
        if (rem_q == W_ZERO) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DIV;
        end
      end
      S_FIX: begin
        if (r0_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
          key_d   = t0_q[WIDTH+1] ? t0_adj_s[WIDTH-1:0] : t0_q[WIDTH-1:0];
          valid_d = 1'b1;
        end else begin
          key_d   = W_ZERO;
          valid_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Normal runs arrive with done already raised by FIX; the degenerate
        // path arrives straight from INIT and raises done here first.
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      e_q     <= W_ZERO;
      y_q     <= W_ZERO;
      r0_q    <= W_ZERO;
      r1_q    <= W_ZERO;
      t0_q    <= T_ZERO;
      t1_q    <= T_ZERO;
      quo_q   <= W_ZERO;
      rem_q   <= W_ZERO;
      p_q     <= T_ZERO;
      cnt_q   <= CNT_ZERO;
      key_q   <= W_ZERO;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      y_q     <= y_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign private_key = key_q;
  assign key_valid   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_private_key_gen.sv
// Bench for private_key_gen: an extended-Euclid reference model predicts
// busy/done/private_key/key_valid every cycle; directed runs also pin
// latencies and results to hand-computed constants.
module tb_private_key_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pk_in;
  logic [31:0] y_in;
  logic [31:0] private_key;
  logic        key_valid;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  private_key_gen #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .public_key (pk_in),
    .y          (y_in),
    .private_key(private_key),
    .key_valid  (key_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // edge counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain extended Euclid on integers.
  function automatic void ref_inv(input longint e, input longint yy,
                                  output longint d, output bit valid,
                                  output int n, output bit degen);
    longint r0, r1, t0, t1, q, tmp;
    d = 0; valid = 0; n = 0; degen = 0;
    if (e == 0 || yy < 2 || e >= yy) begin
      degen = 1;
      return;
    end
    r0 = yy; r1 = e; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      n++;
    end
    if (r0 == 1) begin
      valid = 1;
      d = (t0 < 0) ? t0 + yy : t0;
    end
  endfunction

  // Timeline model: accepts a start when idle, predicts the done edge.
  bit          m_active;
  int          m_done_edge;
  logic [31:0] m_key, m_pend_key;
  logic        m_valid, m_pend_valid;

  always @(posedge clk or posedge rst) begin : model
    longint d;
    bit     v, dg;
    int     n;
    if (rst) begin
      m_active    <= 1'b0;
      m_done_edge <= 0;
      m_key       <= 32'd0;
      m_valid     <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        ref_inv(longint'(pk_in), longint'(y_in), d, v, n, dg);
        m_active     <= 1'b1;
        m_key        <= 32'd0;
        m_valid      <= 1'b0;
        m_pend_key   <= d[31:0];
        m_pend_valid <= v;
        m_done_edge  <= cyc + 1 + (dg ? 2 : 2 + 33 * n);
      end
    end else begin
      if (cyc + 1 == m_done_edge) begin
        m_key   <= m_pend_key;
        m_valid <= m_pend_valid;
      end
      if (cyc + 1 == m_done_edge + 1) m_active <= 1'b0;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_active));
    chk("done", 64'(done), 64'(m_active && (cyc == m_done_edge)));
    chk("private_key", 64'(private_key), 64'(m_key));
    chk("key_valid", 64'(key_valid), 64'(m_valid));
  end

  task automatic run(input logic [31:0] e, input logic [31:0] yy,
                     input logic [31:0] exp_key, input logic exp_valid,
                     input int exp_lat, input bit mid_start, input string nm);
    int  k;
    bit  found = 0;
    @(negedge clk);
    pk_in = e; y_in = yy; start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    pk_in = 32'hDEAD_BEEF; y_in = 32'h0000_0005;
    for (int i = 0; i < 3000; i++) begin
      if (mid_start && i == 20) begin
        pk_in = 32'd3; y_in = 32'd10; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!found) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no done within 3000 cycles", nm);
    end else begin
      chk({nm, "_latency"}, 64'(cyc - k), 64'(exp_lat));
      chk({nm, "_key"}, 64'(private_key), 64'(exp_key));
      chk({nm, "_valid"}, 64'(key_valid), 64'(exp_valid));
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    longint d;
    bit     v, dg;
    int     n;
    rst = 1'b1; start = 1'b0; pk_in = 32'd0; y_in = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_key", 64'(private_key), 64'd0);
    chk("reset_valid", 64'(key_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b0;

    // pin the reference model
    ref_inv(64'd7, 64'd40, d, v, n, dg);
    chk("model_7_40_d", 64'(d), 64'd23);
    chk("model_7_40_n", 64'(n), 64'd4);
    ref_inv(64'd17, 64'd3120, d, v, n, dg);
    chk("model_17_3120_d", 64'(d), 64'd2753);
    ref_inv(64'd7, 64'd76223520, d, v, n, dg);
    chk("model_big_d", 64'(d), 64'd32667223);
    ref_inv(64'd6, 64'd40, d, v, n, dg);
    chk("model_6_40_valid", 64'(v), 64'd0);

    run(32'd7, 32'd40, 32'd23, 1'b1, 134, 1'b0, "e7_y40");
    run(32'd17, 32'd3120, 32'd2753, 1'b1, 134, 1'b0, "e17_y3120");
    run(32'd7, 32'd76223520, 32'd32667223, 1'b1, 101, 1'b0, "e7_big");
    chk("big_inverse_check", 64'((64'd7 * 64'(private_key)) % 64'd76223520), 64'd1);
    run(32'd6, 32'd40, 32'd0, 1'b0, 101, 1'b0, "e6_y40");
    run(32'd0, 32'd40, 32'd0, 1'b0, 2, 1'b0, "e0_y40");
    run(32'd1, 32'd40, 32'd1, 1'b1, 35, 1'b0, "e1_y40");
    run(32'd40, 32'd40, 32'd0, 1'b0, 2, 1'b0, "e_eq_y");
    run(32'd7, 32'd40, 32'd23, 1'b1, 134, 1'b1, "mid_start");

    // start held high: back-to-back degenerate runs, checked by the model
    @(negedge clk);
    pk_in = 32'd0; y_in = 32'd40; start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // asynchronous reset mid-run
    pk_in = 32'd17; y_in = 32'd3120; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_key", 64'(private_key), 64'd0);
    chk("midrst_valid", 64'(key_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    run(32'd17, 32'd3120, 32'd2753, 1'b1, 134, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
